// File: rtl/multi_scale_adder_fp16_pkg.sv
// Shared fp16 types and a combinational fp16 adder (RNE, subnormals flushed to +0).
package dfdd_fp16_pkg;
  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_QNAN = 16'h7E00;

  typedef enum logic {WAIT_SOF, RUN} state_t;

  typedef struct packed {
    logic  sof;
    fp16_t v;
    fp16_t w;
  } pix_t;

  function automatic fp16_t fp16_add(input fp16_t a, input fp16_t b);
    fp16_t       x, y;
    logic [43:0] mx, my, s, norm;
    logic [10:0] mr;
    logic        a_inf, b_inf;
    int          d, p, e;
    if ((a[14:10] == 5'h1F && a[9:0] != 10'd0) || (b[14:10] == 5'h1F && b[9:0] != 10'd0))
      return FP16_QNAN;
    a_inf = (a[14:10] == 5'h1F);
    b_inf = (b[14:10] == 5'h1F);
    if (a_inf && b_inf) return (a[15] == b[15]) ? a : FP16_QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return FP16_ZERO;
    if (a[14:10] == 5'd0) return b;
    if (b[14:10] == 5'd0) return a;
    if (b[14:0] > a[14:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    // 32 extra fraction bits hold every shifted-out bit, so rounding sees an exact sum
    d  = int'(x[14:10]) - int'(y[14:10]);
    mx = {1'b0, 1'b1, x[9:0], 32'd0};
    my = {1'b0, 1'b1, y[9:0], 32'd0} >> d;
    s  = (x[15] == y[15]) ? mx + my : mx - my;
    if (s == 44'd0) return FP16_ZERO;
    p = 0;
    for (int i = 0; i < 44; i++) if (s[i]) p = i;
    e    = int'(x[14:10]) + p - 42;
    norm = s << (43 - p);
    mr   = {1'b0, norm[42:33]};
    if (norm[32] && ((|norm[31:0]) || mr[0])) mr = mr + 11'd1;
    if (mr[10]) begin
      mr = 11'd0;
      e  = e + 1;
    end
    if (e >= 31) return {x[15], 5'h1F, 10'd0};
    if (e <= 0) return FP16_ZERO;
    return {x[15], e[4:0], mr[9:0]};
  endfunction
endpackage

// File: rtl/multi_scale_adder_fp16_if.sv
// Per-scale pixel inputs and summed pixel outputs of the multi-scale adder.
interface multi_scale_adder_fp16_if #(parameter int NUM_SCALES = 4);
  import dfdd_fp16_pkg::*;
  logic [16*NUM_SCALES-1:0] v_i;
  logic [16*NUM_SCALES-1:0] w_i;
  logic [NUM_SCALES-1:0]    valid_i;
  logic [NUM_SCALES-1:0]    sof_i;
  logic [NUM_SCALES-1:0]    scale_en_i;
  fp16_t                    v_o;
  fp16_t                    w_o;
  logic [15:0]              col_o;
  logic [15:0]              row_o;
  logic                     valid_o;
  logic                     overflow_o;
  logic                     resync_o;

  modport master (output v_i, w_i, valid_i, sof_i, scale_en_i,
                  input  v_o, w_o, col_o, row_o, valid_o, overflow_o, resync_o);
  modport slave  (input  v_i, w_i, valid_i, sof_i, scale_en_i,
                  output v_o, w_o, col_o, row_o, valid_o, overflow_o, resync_o);
endinterface

// File: rtl/multi_scale_adder_fp16_fifo.sv
// Single-clock FIFO of {sof,v,w} words; head shows the oldest entry.
module scale_fifo_fp16 import dfdd_fp16_pkg::*; #(
  parameter int DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  pix_t din,
  input  logic pop,
  output pix_t head,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/multi_scale_adder_fp16.sv
// Aligns per-scale V/W fp16 streams on SOF and sums them through registered adder trees.
module multi_scale_adder_fp16 import dfdd_fp16_pkg::*; #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int NUM_SCALES   = 4,
  parameter int BUFFER_DEPTH = 64,
  parameter int FP_WIDTH     = 16
) (
  input logic clk_i,
  input logic rst_i,
  multi_scale_adder_fp16_if.slave bus
);
  localparam int          LEVELS   = $clog2(NUM_SCALES);
  localparam int          LEAVES   = 1 << LEVELS;
  localparam logic [15:0] COL_LAST = 16'(IMAGE_WIDTH - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMAGE_HEIGHT - 1);

  pix_t                  push_dat [NUM_SCALES];
  pix_t                  head     [NUM_SCALES];
  logic [NUM_SCALES-1:0] full, empty, pop, head_sof;
  logic [NUM_SCALES-1:0] mask, mask_nx, cur_mask, en_eff;
  state_t                state, state_nx;
  logic [15:0]           col, row, col_nx, row_nx, emit_col, emit_row;
  logic                  expect_sof, expect_sof_nx, emit, resync, resync_nx, overflow;
  logic                  all_ready, sof_all, sof_any;
  logic [FP_WIDTH*LEAVES-1:0] leaf_v, leaf_w;

  for (genvar s = 0; s < NUM_SCALES; s++) begin : g_fifo
    assign push_dat[s] = '{sof: bus.sof_i[s], v: bus.v_i[16*s +: 16], w: bus.w_i[16*s +: 16]};
    assign head_sof[s] = head[s].sof;
    scale_fifo_fp16 #(.DEPTH(BUFFER_DEPTH)) u_fifo (
      .clk(clk_i), .rst(rst_i), .push(bus.valid_i[s]), .din(push_dat[s]),
      .pop(pop[s]), .head(head[s]), .full(full[s]), .empty(empty[s])
    );
  end

  always_comb begin
    en_eff        = (bus.scale_en_i == '0) ? '1 : bus.scale_en_i;
    cur_mask      = (state == RUN) ? mask : en_eff;
    all_ready     = &(~empty | ~cur_mask);
    sof_all       = &(head_sof | ~cur_mask);
    sof_any       = |(head_sof & cur_mask);
    state_nx      = state;
    mask_nx       = mask;
    col_nx        = col;
    row_nx        = row;
    expect_sof_nx = expect_sof;
    emit          = 1'b0;
    resync_nx     = 1'b0;
    emit_col      = col;
    emit_row      = row;
    pop           = ~cur_mask & ~empty;
    if (state == WAIT_SOF) begin
      pop = pop | (cur_mask & ~empty & ~head_sof);
      if (all_ready && sof_all) begin
        state_nx      = RUN;
        mask_nx       = en_eff;
        col_nx        = '0;
        row_nx        = '0;
        expect_sof_nx = 1'b1;
      end
    end else if (all_ready) begin
      pop = pop | cur_mask;
      if ((sof_any && !sof_all) || (!sof_all && expect_sof)) begin
        resync_nx = 1'b1;
        state_nx  = WAIT_SOF;
      end else begin
        emit          = 1'b1;
        expect_sof_nx = 1'b0;
        // an all-SOF set always opens a frame, even mid-frame
        if (sof_all) begin
          emit_col = '0;
          emit_row = '0;
        end
        if (emit_col == COL_LAST) begin
          col_nx = '0;
          if (emit_row == ROW_LAST) begin
            row_nx        = '0;
            expect_sof_nx = 1'b1;
          end else begin
            row_nx = emit_row + 16'd1;
          end
        end else begin
          col_nx = emit_col + 16'd1;
          row_nx = emit_row;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= WAIT_SOF;
      mask       <= '0;
      col        <= '0;
      row        <= '0;
      expect_sof <= 1'b1;
      resync     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nx;
      mask       <= mask_nx;
      col        <= col_nx;
      row        <= row_nx;
      expect_sof <= expect_sof_nx;
      resync     <= resync_nx;
      overflow   <= overflow | (|(bus.valid_i & full & ~pop));
    end
  end

  always_comb begin
    leaf_v = '0;
    leaf_w = '0;
    for (int s = 0; s < NUM_SCALES; s++) begin
      if (cur_mask[s]) begin
        leaf_v[FP_WIDTH*s +: FP_WIDTH] = head[s].v;
        leaf_w[FP_WIDTH*s +: FP_WIDTH] = head[s].w;
      end
    end
  end

  // level 0 captures the popped set; each later level halves the operand count
  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    localparam int N = LEAVES >> l;
    logic [FP_WIDTH*N-1:0] vs, ws;
    logic                  vld;
    logic [15:0]           c, r;
    if (l == 0) begin : g_in
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vs <= '0; ws <= '0; vld <= 1'b0; c <= '0; r <= '0;
        end else begin
          vld <= emit;
          if (emit) begin
            vs <= leaf_v;
            ws <= leaf_w;
            c  <= emit_col;
            r  <= emit_row;
          end
        end
      end
    end else begin : g_add
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          vs <= '0; ws <= '0; vld <= 1'b0; c <= '0; r <= '0;
        end else begin
          vld <= lvl[l-1].vld;
          c   <= lvl[l-1].c;
          r   <= lvl[l-1].r;
          for (int j = 0; j < N; j++) begin
            vs[FP_WIDTH*j +: FP_WIDTH] <= fp16_add(lvl[l-1].vs[2*FP_WIDTH*j +: FP_WIDTH],
                                                   lvl[l-1].vs[2*FP_WIDTH*j+FP_WIDTH +: FP_WIDTH]);
            ws[FP_WIDTH*j +: FP_WIDTH] <= fp16_add(lvl[l-1].ws[2*FP_WIDTH*j +: FP_WIDTH],
                                                   lvl[l-1].ws[2*FP_WIDTH*j+FP_WIDTH +: FP_WIDTH]);
          end
        end
      end
    end
  end

  assign bus.v_o        = lvl[LEVELS].vs[FP_WIDTH-1:0];
  assign bus.w_o        = lvl[LEVELS].ws[FP_WIDTH-1:0];
  assign bus.col_o      = lvl[LEVELS].c;
  assign bus.row_o      = lvl[LEVELS].r;
  assign bus.valid_o    = lvl[LEVELS].vld;
  assign bus.overflow_o = overflow;
  assign bus.resync_o   = resync;
endmodule
